accum_limit_ctrl: RTL

ACCUM_LIMIT_CTRL -- requirements
Module: accum_limit_ctrl

---
 rtl/accum_limit_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/accum_limit_ctrl.sv
// accum_limit_ctrl: button-driven saturating accumulator with a limit alarm.
// Four-state Moore FSM (INIT/WAIT/ADD/ALARM) consuming button rising edges.
// Optional feature: define BUTTON_DEBOUNCE_EN to put a DEB_CYCLES stability
// filter in front of both buttons; undefined, the raw levels are used.
module accum_limit_ctrl #(
    parameter int          WIDTH      = 8,
    parameter int unsigned LIMIT      = 200,
    parameter int          DEB_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             b_add,
    input  logic             b_clr,
    input  logic [WIDTH-1:0] step,
    output logic [WIDTH-1:0] acc,
    output logic             alarm,
    output logic             add_pulse,
    output logic             clr_pulse,
    output logic [3:0]       state_led
);

    typedef enum logic [1:0] {S_INIT, S_WAIT, S_ADD, S_ALARM} state_t;

    // Elaboration-time sanity on the parameter ranges.
    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("accum_limit_ctrl: WIDTH out of range");
        end
        if (DEB_CYCLES < 2) begin : g_bad_deb
            $error("accum_limit_ctrl: DEB_CYCLES must be >= 2");
        end
    endgenerate

    state_t           state, state_nx;
    logic [1:0]       raw;      // {clr, add}
    logic [1:0]       lvl;      // conditioned button levels
    logic [1:0]       lvl_q;    // previous-cycle sample of lvl
    logic [1:0]       rise;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] sat_sum;
    logic             at_limit;

    assign raw = {b_clr, b_add};

`ifdef BUTTON_DEBOUNCE_EN
    localparam int CW = $clog2(DEB_CYCLES + 1);
    logic [1:0]         flt;
    logic [1:0][CW-1:0] cnt;

    // Debounce: flip the filtered level only after DEB_CYCLES consecutive
    // cycles of disagreement with the raw input; any agreement restarts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flt <= '0;
            cnt <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (raw[i] != flt[i]) begin
                    if (cnt[i] == CW'(DEB_CYCLES - 1)) begin
                        flt[i] <= raw[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    assign lvl = flt;
`else
    assign lvl = raw;
`endif

    // Previous-cycle sample; cleared by reset so a held button rises once after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lvl_q <= '0;
        else        lvl_q <= lvl;
    end

    assign rise     = lvl & ~lvl_q;
    assign sum      = {1'b0, acc} + {1'b0, step};
    assign sat_sum  = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
    assign at_limit = (acc >= WIDTH'(LIMIT));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_INIT;
        else        state <= state_nx;
    end

    // Next-state: alarm beats clear beats add in WAIT; unconsumed rises are dropped.
    always_comb begin
        state_nx = state;
        case (state)
            S_INIT:  state_nx = S_WAIT;
            S_WAIT: begin
                if (at_limit)     state_nx = S_ALARM;
                else if (rise[1]) state_nx = S_INIT;
                else if (rise[0]) state_nx = S_ADD;
            end
            S_ADD:   state_nx = S_WAIT;
            S_ALARM: if (rise[1]) state_nx = S_INIT;
            default: state_nx = S_INIT;
        endcase
    end

    // Accumulator: cleared in INIT, saturating add in ADD, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                acc <= '0;
        else if (state == S_INIT)  acc <= '0;
        else if (state == S_ADD)   acc <= sat_sum;
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        alarm     = 1'b0;
        add_pulse = 1'b0;
        clr_pulse = 1'b0;
        state_led = 4'b0000;
        case (state)
            S_INIT:  begin clr_pulse = 1'b1; state_led = 4'b0001; end
            S_WAIT:  state_led = 4'b0010;
            S_ADD:   begin add_pulse = 1'b1; state_led = 4'b0100; end
            S_ALARM: begin alarm = 1'b1; state_led = 4'b1000; end
            default: state_led = 4'b0000;
        endcase
    end

endmodule
